// File: rtl/position_update_scheduler_if.sv
// Handshake/status bundle between the position-update scheduler and its neighbours.
// Latency: none (wires only).
// Backpressure: none; the scheduler paces the updaters through ready.
interface position_update_scheduler_if #(
    parameter int N_CELLS = 27,
    parameter int TS_W    = 32
);
    logic               start;
    logic               abort;
    logic [N_CELLS-1:0] upd_done;
    logic [N_CELLS-1:0] ring_valid;
    logic               ready;
    logic [1:0]         double_buffer;
    logic               busy;
    logic               phase_done;
    logic [TS_W-1:0]    timestep;
    logic               timeout_err;
    logic [31:0]        run_cycles;

    // Scheduler side: drives the updater controls and status.
    modport master (
        input  start, abort, upd_done, ring_valid,
        output ready, double_buffer, busy, phase_done, timestep, timeout_err, run_cycles
    );

    // Timestep controller / updater array side.
    modport slave (
        output start, abort, upd_done, ring_valid,
        input  ready, double_buffer, busy, phase_done, timestep, timeout_err, run_cycles
    );
endinterface

// File: rtl/position_update_scheduler.sv
// Sequences one position-update timestep: arm, release, wait for quiet, swap buffers, pulse done.
// Latency: ARM_CYCLES + (>= QUIET_CYCLES RUN) + SWAP + DONE cycles from start to phase_done.
// Backpressure: start ignored while busy; abort returns to IDLE from any active state.
module position_update_scheduler #(
    parameter int ARM_CYCLES   = 2,
    parameter int QUIET_CYCLES = 27,
    parameter int TIMEOUT      = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    position_update_scheduler_if.master bus
);
    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int QW    = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        SWAP,
        DONE,
        ERR
    } state_t;

    state_t           state;
    logic [ARM_W-1:0] arm_cnt;
    logic [31:0]      run_cnt;
    logic [QW-1:0]    quiet_cnt;
    logic             quiet;

    // Phase is quiet when every updater is done and no particle sits on the migration ring.
    assign quiet = (&bus.upd_done) && !(|bus.ring_valid);

    // Phase FSM; all outputs registered and reflect the state they are entered with.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            arm_cnt           <= '0;
            run_cnt           <= '0;
            quiet_cnt         <= '0;
            bus.ready         <= 1'b0;
            bus.double_buffer <= 2'b01;
            bus.busy          <= 1'b0;
            bus.phase_done    <= 1'b0;
            bus.timestep      <= '0;
            bus.timeout_err   <= 1'b0;
            bus.run_cycles    <= '0;
        end else begin
            bus.phase_done <= 1'b0;
            if (bus.abort && state != IDLE) begin
                // Abort keeps whatever swap/increment already happened and the error flag.
                state          <= IDLE;
                bus.ready      <= 1'b0;
                bus.busy       <= 1'b0;
                bus.run_cycles <= run_cnt;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state           <= ARM;
                            arm_cnt         <= ARM_W'(ARM_CYCLES - 1);
                            run_cnt         <= '0;
                            quiet_cnt       <= '0;
                            bus.timeout_err <= 1'b0;
                            bus.busy        <= 1'b1;
                        end
                    end
                    ARM: begin
                        // Updaters latch their base address while ready is low.
                        if (arm_cnt == '0) begin
                            state     <= RUN;
                            bus.ready <= 1'b1;
                        end else begin
                            arm_cnt <= arm_cnt - 1'b1;
                        end
                    end
                    RUN: begin
                        if (run_cnt != '1) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                        // Done is a live level: any disturbance restarts the quiet window.
                        quiet_cnt <= quiet ? quiet_cnt + 1'b1 : '0;
                        if (quiet && quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
                            state             <= SWAP;
                            bus.ready         <= 1'b0;
                            bus.double_buffer <= {bus.double_buffer[0], bus.double_buffer[1]};
                        end else if (run_cnt == 32'(TIMEOUT - 1)) begin
                            state           <= ERR;
                            bus.ready       <= 1'b0;
                            bus.timeout_err <= 1'b1;
                        end
                    end
                    SWAP: begin
                        state          <= DONE;
                        bus.run_cycles <= run_cnt;
                        bus.phase_done <= 1'b1;
                        bus.timestep   <= bus.timestep + 1'b1;
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    ERR: begin
                        // Parked until abort or reset.
                        state <= ERR;
                    end
                    default: begin
                        state     <= IDLE;
                        bus.ready <= 1'b0;
                        bus.busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_position_update_scheduler.sv
// Self-checking bench for the position-update scheduler.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_position_update_scheduler;
    localparam int N   = 27;
    localparam int ARM = 2;
    localparam int QC  = 27;
    localparam int TO  = 4096;

    logic clk;
    logic rst;

    position_update_scheduler_if #(.N_CELLS(N), .TS_W(32)) bus ();

    position_update_scheduler #(
        .ARM_CYCLES  (ARM),
        .QUIET_CYCLES(QC),
        .TIMEOUT     (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference state of the outputs.
    logic [1:0]  exp_db;
    logic [31:0] exp_ts;
    logic [31:0] exp_rc;

    // Per-RUN-cycle input patterns for the next phase.
    logic [N-1:0] done_pat [TO];
    logic [N-1:0] ring_pat [TO];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_quiet();
        for (int k = 0; k < TO; k++) begin
            done_pat[k] = '1;
            ring_pat[k] = '0;
        end
    endtask

    // Phase ends at the first RUN index that closes a window of QC quiet cycles,
    // otherwise at the last permitted RUN cycle with a timeout.
    function automatic void predict(output int last_k, output bit timed_out);
        timed_out = 1'b1;
        last_k    = TO - 1;
        for (int k = QC - 1; k < TO; k++) begin
            bit win_ok;
            win_ok = 1'b1;
            for (int j = k - QC + 1; j <= k; j++) begin
                if (done_pat[j] != {N{1'b1}} || ring_pat[j] != '0) win_ok = 1'b0;
            end
            if (win_ok) begin
                last_k    = k;
                timed_out = 1'b0;
                return;
            end
        end
    endfunction

    // Runs one phase from IDLE using the current patterns; ends in IDLE or ERR.
    task automatic do_phase(input string tag, output bit timed_out);
        int last_k;
        predict(last_k, timed_out);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL %s arm_entry: busy=%b terr=%b required busy=1 terr=0", tag, bus.busy, bus.timeout_err);
        end
        for (int a = 0; a < ARM; a++) begin
            total++;
            if (bus.ready !== 1'b0) begin
                bad++;
                $display("FAIL %s arm_ready: ready=%b required 0", tag, bus.ready);
            end
            tick();
        end
        for (int k = 0; k <= last_k; k++) begin
            bus.upd_done   = done_pat[k];
            bus.ring_valid = ring_pat[k];
            total++;
            if (bus.ready !== 1'b1) begin
                bad++;
                $display("FAIL %s run_ready k=%0d: ready=%b required 1", tag, k, bus.ready);
            end
            tick();
        end
        bus.upd_done   = '1;
        bus.ring_valid = '0;
        if (timed_out) begin
            total++;
            if (bus.ready !== 1'b0 || bus.timeout_err !== 1'b1 || bus.busy !== 1'b1 ||
                bus.double_buffer !== exp_db) begin
                bad++;
                $display("FAIL %s err_state: ready=%b terr=%b busy=%b db=%b required 0 1 1 %b",
                         tag, bus.ready, bus.timeout_err, bus.busy, bus.double_buffer, exp_db);
            end
            return;
        end
        exp_db = {exp_db[0], exp_db[1]};
        total++;
        if (bus.ready !== 1'b0 || bus.phase_done !== 1'b0 || bus.double_buffer !== exp_db) begin
            bad++;
            $display("FAIL %s swap: ready=%b pd=%b db=%b required 0 0 %b",
                     tag, bus.ready, bus.phase_done, bus.double_buffer, exp_db);
        end
        tick();
        exp_ts++;
        total++;
        if (bus.phase_done !== 1'b1 || bus.timestep !== exp_ts) begin
            bad++;
            $display("FAIL %s done: pd=%b ts=%0d required 1 %0d", tag, bus.phase_done, bus.timestep, exp_ts);
        end
        tick();
        exp_rc = 32'(last_k + 1);
        total++;
        if (bus.phase_done !== 1'b0 || bus.busy !== 1'b0 || bus.run_cycles !== exp_rc ||
            bus.double_buffer !== exp_db) begin
            bad++;
            $display("FAIL %s idle: pd=%b busy=%b rc=%0d db=%b required 0 0 %0d %b",
                     tag, bus.phase_done, bus.busy, bus.run_cycles, bus.double_buffer, exp_rc, exp_db);
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus.ready !== 1'b0 || bus.double_buffer !== 2'b01 || bus.busy !== 1'b0 ||
            bus.phase_done !== 1'b0 || bus.timestep !== 32'd0 || bus.timeout_err !== 1'b0 ||
            bus.run_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset: ready=%b db=%b busy=%b pd=%b ts=%0d terr=%b rc=%0d required 0 01 0 0 0 0 0",
                     bus.ready, bus.double_buffer, bus.busy, bus.phase_done, bus.timestep,
                     bus.timeout_err, bus.run_cycles);
        end
    endtask

    task automatic test_basic();
        bit to;
        fill_quiet();
        do_phase("basic", to);
        total++;
        if (bus.run_cycles !== 32'd27) begin
            bad++;
            $display("FAIL basic_run_cycles: rc=%0d required 27", bus.run_cycles);
        end
    endtask

    task automatic test_migration();
        bit to;
        fill_quiet();
        ring_pat[20][5] = 1'b1;
        do_phase("migration", to);
        total++;
        if (bus.run_cycles !== 32'd48) begin
            bad++;
            $display("FAIL migration_run_cycles: rc=%0d required 48", bus.run_cycles);
        end
    endtask

    task automatic test_random();
        bit to;
        for (int p = 0; p < 4; p++) begin
            fill_quiet();
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) done_pat[k][$urandom_range(0, N - 1)] = 1'b0;
                    else                           ring_pat[k][$urandom_range(0, N - 1)] = 1'b1;
                end
            end
            do_phase("random", to);
        end
    endtask

    task automatic test_timeout();
        bit to;
        fill_quiet();
        for (int k = 0; k < TO; k++) done_pat[k][0] = 1'b0;
        do_phase("timeout", to);
        total++;
        if (to !== 1'b1) begin
            bad++;
            $display("FAIL timeout_model: timed_out=%b required 1", to);
        end
        bus.upd_done[0] = 1'b0;
        repeat (5) tick();
        total++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_hold: ready=%b busy=%b terr=%b required 0 1 1", bus.ready, bus.busy, bus.timeout_err);
        end
        bus.upd_done = '1;
        bus.abort    = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_rc    = 32'(TO);
        total++;
        if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1 || bus.run_cycles !== exp_rc ||
            bus.double_buffer !== exp_db || bus.timestep !== exp_ts) begin
            bad++;
            $display("FAIL timeout_abort: busy=%b terr=%b rc=%0d db=%b ts=%0d required 0 1 %0d %b %0d",
                     bus.busy, bus.timeout_err, bus.run_cycles, bus.double_buffer, bus.timestep,
                     exp_rc, exp_db, exp_ts);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_clear: terr=%b busy=%b required 0 1", bus.timeout_err, bus.busy);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_rc    = 32'd0;
    endtask

    task automatic test_abort();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (ARM) tick();
        repeat (10) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_rc    = 32'd10;
        total++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.run_cycles !== exp_rc) begin
            bad++;
            $display("FAIL abort_idle: busy=%b ready=%b rc=%0d required 0 0 10", bus.busy, bus.ready, bus.run_cycles);
        end
        for (int c = 0; c < 40; c++) begin
            total++;
            if (bus.phase_done !== 1'b0 || bus.timestep !== exp_ts || bus.double_buffer !== exp_db) begin
                bad++;
                $display("FAIL abort_quiet c=%0d: pd=%b ts=%0d db=%b required 0 %0d %b",
                         c, bus.phase_done, bus.timestep, bus.double_buffer, exp_ts, exp_db);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int n;
        int phase_len;
        phase_len = 1 + ARM + QC + 2;
        pulses    = 0;
        n         = 0;
        bus.start = 1'b1;
        while (pulses < 3 && n < 200) begin
            tick();
            n++;
            if (bus.phase_done === 1'b1) begin
                pulses++;
                exp_db = {exp_db[0], exp_db[1]};
                exp_ts++;
                total++;
                if (n != pulses * phase_len - 1 || bus.double_buffer !== exp_db || bus.timestep !== exp_ts) begin
                    bad++;
                    $display("FAIL b2b_pulse%0d: at=%0d db=%b ts=%0d required %0d %b %0d",
                             pulses, n, bus.double_buffer, bus.timestep, pulses * phase_len - 1, exp_db, exp_ts);
                end
            end
        end
        bus.start = 1'b0;
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL b2b_count: pulses=%0d required 3", pulses);
        end
        tick();
        exp_rc = 32'(QC);
        total++;
        if (bus.busy !== 1'b0 || bus.run_cycles !== exp_rc) begin
            bad++;
            $display("FAIL b2b_end: busy=%b rc=%0d required 0 %0d", bus.busy, bus.run_cycles, exp_rc);
        end
    endtask

    task automatic test_async_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (ARM + 5) tick();
        total++;
        if (bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: ready=%b required 1", bus.ready);
        end
        #3;
        rst = 1'b0;
        #1;
        exp_db = 2'b01;
        exp_ts = 32'd0;
        exp_rc = 32'd0;
        total++;
        if (bus.ready !== 1'b0 || bus.double_buffer !== exp_db || bus.timestep !== exp_ts ||
            bus.busy !== 1'b0 || bus.run_cycles !== exp_rc) begin
            bad++;
            $display("FAIL areset: ready=%b db=%b ts=%0d busy=%b rc=%0d required 0 01 0 0 0",
                     bus.ready, bus.double_buffer, bus.timestep, bus.busy, bus.run_cycles);
        end
        #1;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        exp_db         = 2'b01;
        exp_ts         = 32'd0;
        exp_rc         = 32'd0;
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.upd_done   = '1;
        bus.ring_valid = '0;
        #22;
        test_reset();
        rst = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_migration();
        test_random();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
